// File: rtl/hps_gpio_pkg.sv
// Shared register map and mode encodings for the HPS GPIO bank.
package hps_gpio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_INFO    = 3'd6;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

  // Mode byte reported in the INFO register.
  function automatic logic [7:0] info_mode(int unsigned edge_type, int unsigned irq_mode);
    return 8'((edge_type << 1) | irq_mode);
  endfunction

endpackage

// File: rtl/hps_gpio_sync.sv
// Input synchroniser, previous-value flop and warm-up gated edge detector.
module hps_gpio_sync
  import hps_gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  localparam int unsigned WarmMax = STAGES + 1;
  localparam int unsigned CntW    = $clog2(WarmMax + 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CntW-1:0]  warm_q;
  logic             warm_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= pins_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
      if (!warm_done) begin
        warm_q <= warm_q + CntW'(1);
      end
    end
  end

  // Edges stay masked until the chain and prev flop hold real samples.
  assign warm_done = (warm_q == CntW'(WarmMax));
  assign sync_o    = sync_q[STAGES-1];

  always_comb begin
    edge_o = '0;
    if (warm_done) begin
      if (EDGE_TYPE == EDGE_RISING) begin
        edge_o = sync_o & ~prev_q;
      end else if (EDGE_TYPE == EDGE_FALLING) begin
        edge_o = ~sync_o & prev_q;
      end else begin
        edge_o = sync_o ^ prev_q;
      end
    end
  end

endmodule

// File: rtl/hps_gpio_bank.sv
// Avalon-MM GPIO bank: data/direction registers, set/clear, edge capture and irq.
module hps_gpio_bank
  import hps_gpio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '1,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned           IRQ_MODE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  localparam logic [31:0] InfoWord = {16'h0, info_mode(EDGE_TYPE, IRQ_MODE), 8'(DATA_WIDTH)};

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;

  logic [DATA_WIDTH-1:0] sync_in, edge_pulse, wd;
  logic                  wr_en;
  logic                  unused_wd;

  hps_gpio_sync #(
    .WIDTH     (DATA_WIDTH),
    .STAGES    (SYNC_STAGES),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .pins_i (in_port),
    .sync_o (sync_in),
    .edge_o (edge_pulse)
  );

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    // A newly detected edge always wins over a same-cycle W1C.
    edgecap_d  = edgecap_q | edge_pulse;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    data_out_d = wd;
        ADDR_DIR:     dir_d      = wd;
        ADDR_IRQMASK: mask_d     = wd;
        ADDR_EDGECAP: edgecap_d  = (edgecap_q & ~wd) | edge_pulse;
        ADDR_OUTSET:  data_out_d = data_out_q | wd;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
        default:      ;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'((data_out_q & dir_q) | (sync_in & ~dir_q));
      ADDR_DIR:     readdata_d = 32'(dir_q);
      ADDR_IRQMASK: readdata_d = 32'(mask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      ADDR_INFO:    readdata_d = InfoWord;
      default:      readdata_d = '0;
    endcase
  end

  always_comb begin
    if (IRQ_MODE == IRQ_EDGE) begin
      irq_d = |(edgecap_q & mask_q);
    end else begin
      irq_d = |(sync_in & mask_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= DIR_RESET;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign out_port = data_out_q;
  assign out_en   = dir_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_hps_gpio_bank.sv
// Bench for hps_gpio_bank: three configurations sharing one bus, checked against a model.
module tb_hps_gpio_bank;
  import hps_gpio_pkg::*;

  localparam int SA = 2;
  localparam int SL = 4;
  localparam int SB = 3;
  localparam logic [31:0] RV_B = 32'h1234_5678;
  localparam logic [31:0] DR_B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = '0;
  logic        cs_a = 1'b0, cs_l = 1'b0, cs_b = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;

  logic [7:0]  in_port_a = '0, out_port_a, out_en_a;
  logic [7:0]  in_port_l = '0, out_port_l, out_en_l;
  logic [31:0] in_port_b = '0, out_port_b, out_en_b;
  logic [31:0] readdata_a, readdata_l, readdata_b;
  logic        irq_a, irq_l, irq_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hps_gpio_bank #(
    .DATA_WIDTH (8), .RESET_VALUE (8'hA5), .DIR_RESET (8'hFF),
    .SYNC_STAGES (SA), .EDGE_TYPE (EDGE_RISING), .IRQ_MODE (IRQ_EDGE)
  ) dut_a (
    .clk (clk), .reset_n (reset_n), .address (address), .chipselect (cs_a),
    .write_n (write_n), .writedata (writedata), .readdata (readdata_a),
    .in_port (in_port_a), .out_port (out_port_a), .out_en (out_en_a), .irq (irq_a)
  );

  hps_gpio_bank #(
    .DATA_WIDTH (8), .RESET_VALUE (8'h00), .DIR_RESET (8'hFF),
    .SYNC_STAGES (SL), .EDGE_TYPE (EDGE_RISING), .IRQ_MODE (IRQ_LEVEL)
  ) dut_l (
    .clk (clk), .reset_n (reset_n), .address (address), .chipselect (cs_l),
    .write_n (write_n), .writedata (writedata), .readdata (readdata_l),
    .in_port (in_port_l), .out_port (out_port_l), .out_en (out_en_l), .irq (irq_l)
  );

  hps_gpio_bank #(
    .DATA_WIDTH (32), .RESET_VALUE (RV_B), .DIR_RESET (DR_B),
    .SYNC_STAGES (SB), .EDGE_TYPE (EDGE_ANY), .IRQ_MODE (IRQ_EDGE)
  ) dut_b (
    .clk (clk), .reset_n (reset_n), .address (address), .chipselect (cs_b),
    .write_n (write_n), .writedata (writedata), .readdata (readdata_b),
    .in_port (in_port_b), .out_port (out_port_b), .out_en (out_en_b), .irq (irq_b)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    {cs_b, cs_l, cs_a} = '0;
    write_n = 1'b1;
    address = '0;
    writedata = '0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] sel, input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    {cs_b, cs_l, cs_a} = sel;
    write_n = 1'b0;
    address = addr;
    writedata = data;
    @(posedge clk);
    #1;
    {cs_b, cs_l, cs_a} = '0;
    write_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_port_a !== 8'hA5) begin failures++;
      $display("FAIL rst_out_port_a got=%h exp=a5", out_port_a); end
    checks++; if (out_en_a !== 8'hFF) begin failures++;
      $display("FAIL rst_out_en_a got=%h exp=ff", out_en_a); end
    checks++; if ({irq_a, irq_l, irq_b} !== 3'b000) begin failures++;
      $display("FAIL rst_irq got=%b exp=000", {irq_a, irq_l, irq_b}); end
    checks++; if ((readdata_a | readdata_l | readdata_b) !== 32'h0) begin failures++;
      $display("FAIL rst_readdata got=%h exp=0", readdata_a | readdata_l | readdata_b); end
    checks++; if (out_port_b !== RV_B || out_en_b !== DR_B) begin failures++;
      $display("FAIL rst_b got=%h/%h exp=%h/%h", out_port_b, out_en_b, RV_B, DR_B); end
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk) address = ADDR_INFO;
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h0000_0108) begin failures++;
      $display("FAIL info_a got=%h exp=00000108", readdata_a); end
    checks++; if (readdata_l !== 32'h0000_0008) begin failures++;
      $display("FAIL info_l got=%h exp=00000008", readdata_l); end
    checks++; if (readdata_b !== 32'h0000_0520) begin failures++;
      $display("FAIL info_b got=%h exp=00000520", readdata_b); end
  endtask

  task automatic test_out_regs();
    in_port_a = 8'h00;
    apply_reset();
    bus_write(3'b001, ADDR_DATA, 32'hFFFF_FF3C);
    checks++; if (out_port_a !== 8'h3C) begin failures++;
      $display("FAIL data_write got=%h exp=3c", out_port_a); end
    bus_write(3'b001, ADDR_OUTSET, 32'h0000_0001);
    checks++; if (out_port_a !== 8'h3D) begin failures++;
      $display("FAIL outset got=%h exp=3d", out_port_a); end
    bus_write(3'b001, ADDR_OUTCLR, 32'h0000_000C);
    checks++; if (out_port_a !== 8'h31) begin failures++;
      $display("FAIL outclr got=%h exp=31", out_port_a); end
    bus_write(3'b001, 3'd7, 32'h0000_00FF);
    checks++; if (out_port_a !== 8'h31) begin failures++;
      $display("FAIL reserved_write got=%h exp=31", out_port_a); end
    in_port_a = 8'hF0;
    bus_write(3'b001, ADDR_DIR, 32'hFFFF_FF0F);
    checks++; if (out_en_a !== 8'h0F) begin failures++;
      $display("FAIL dir_write got=%h exp=0f", out_en_a); end
    repeat (SA + 1) @(posedge clk);
    @(negedge clk) address = ADDR_DATA;
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h0000_00F1) begin failures++;
      $display("FAIL data_mixed_read got=%h exp=000000f1", readdata_a); end
    @(negedge clk) address = ADDR_DIR;
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h0000_000F) begin failures++;
      $display("FAIL dir_read got=%h exp=0000000f", readdata_a); end
    @(negedge clk) address = ADDR_OUTSET;
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h0) begin failures++;
      $display("FAIL outset_read got=%h exp=0", readdata_a); end
    @(negedge clk) address = 3'd7;
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h0) begin failures++;
      $display("FAIL reserved_read got=%h exp=0", readdata_a); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] exp_cap;
    logic        exp_irq;
    in_port_a = 8'h04;
    apply_reset();
    bus_write(3'b001, ADDR_IRQMASK, 32'h0000_0004);
    repeat (6) @(posedge clk);
    @(negedge clk) address = ADDR_EDGECAP;
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h0 || irq_a !== 1'b0) begin failures++;
      $display("FAIL no_capture_at_reset got=%h/%b exp=0/0", readdata_a, irq_a); end
    @(negedge clk) in_port_a = 8'h00;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (readdata_a !== 32'h0) begin failures++;
      $display("FAIL falling_ignored got=%h exp=0", readdata_a); end
    @(negedge clk) in_port_a = 8'h04;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      exp_cap = (k >= SA + 1) ? 32'h4 : 32'h0;
      exp_irq = (k >= SA + 1);
      checks++; if (readdata_a !== exp_cap) begin failures++;
        $display("FAIL rise_cap k=%0d got=%h exp=%h", k, readdata_a, exp_cap); end
      checks++; if (irq_a !== exp_irq) begin failures++;
        $display("FAIL rise_irq k=%0d got=%b exp=%b", k, irq_a, exp_irq); end
    end
    // Re-arm a rising edge so its capture coincides with a W1C write.
    @(negedge clk) in_port_a = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk) in_port_a = 8'h04;
    @(posedge clk);
    repeat (SA - 1) @(posedge clk);
    bus_write(3'b001, ADDR_EDGECAP, 32'h0000_0004);
    checks++; if (irq_a !== 1'b1) begin failures++;
      $display("FAIL w1c_race_irq0 got=%b exp=1", irq_a); end
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h4) begin failures++;
      $display("FAIL w1c_race_cap got=%h exp=4", readdata_a); end
    checks++; if (irq_a !== 1'b1) begin failures++;
      $display("FAIL w1c_race_irq1 got=%b exp=1", irq_a); end
    bus_write(3'b001, ADDR_EDGECAP, 32'h0000_0004);
    checks++; if (irq_a !== 1'b1) begin failures++;
      $display("FAIL w1c_irq_lag got=%b exp=1", irq_a); end
    @(posedge clk); #1;
    checks++; if (readdata_a !== 32'h0 || irq_a !== 1'b0) begin failures++;
      $display("FAIL w1c_clear got=%h/%b exp=0/0", readdata_a, irq_a); end
  endtask

  task automatic test_level_irq();
    logic exp_irq;
    in_port_l = 8'h00;
    apply_reset();
    bus_write(3'b010, ADDR_IRQMASK, 32'h0000_0001);
    repeat (6) @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk) in_port_l = (k < 5) ? 8'h02 : 8'h00;
      @(posedge clk); #1;
      checks++; if (irq_l !== 1'b0) begin failures++;
        $display("FAIL level_unmasked k=%0d got=%b exp=0", k, irq_l); end
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk) in_port_l = (k < 5) ? 8'h01 : 8'h00;
      @(posedge clk); #1;
      exp_irq = (k >= SL) && (k <= SL + 4);
      checks++; if (irq_l !== exp_irq) begin failures++;
        $display("FAIL level_pulse k=%0d got=%b exp=%b", k, irq_l, exp_irq); end
    end
  endtask

  // Reference state for dut_b, advanced once per clock edge.
  logic [31:0] m_dout, m_dir, m_mask, m_ecap;
  logic [31:0] hist[$];
  int          m_k;

  task automatic model_reset();
    m_dout = RV_B;
    m_dir  = DR_B;
    m_mask = '0;
    m_ecap = '0;
    m_k    = 0;
    hist.delete();
    hist.push_back('0);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic [31:0] pins_seen);
    case (a)
      3'd0:    return (m_dout & m_dir) | (pins_seen & ~m_dir);
      3'd1:    return m_dir;
      3'd2:    return m_mask;
      3'd3:    return m_ecap;
      3'd6:    return 32'h0000_0520;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_random_any();
    logic [31:0] pins, wd, seen, ev, exp_rd;
    logic [2:0]  wa;
    logic        exp_irq;
    int          op;
    in_port_b = '0;
    apply_reset();
    model_reset();
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      pins = $urandom;
      op   = $urandom_range(0, 9);
      wd   = $urandom;
      if (op == 4) wd = wd & $urandom;
      case (op)
        4: wa = ADDR_EDGECAP;
        5: wa = ADDR_DATA;
        6: wa = ADDR_OUTSET;
        7: wa = ADDR_OUTCLR;
        8: wa = ADDR_DIR;
        9: wa = ADDR_IRQMASK;
        default: wa = 3'($urandom_range(0, 7));
      endcase
      in_port_b = pins;
      address = wa;
      if (op >= 4) begin
        cs_b = 1'b1;
        write_n = 1'b0;
        writedata = wd;
      end
      @(posedge clk);
      m_k++;
      hist.push_back(pins);
      // Pins sampled at edge j become visible after edge j+SB-1.
      seen    = (m_k - SB >= 1) ? hist[m_k - SB] : 32'h0;
      exp_rd  = model_read(wa, seen);
      exp_irq = |(m_ecap & m_mask);
      // A change between two post-reset samples is captured SB edges later.
      ev = (m_k - SB >= 2) ? (hist[m_k - SB] ^ hist[m_k - SB - 1]) : 32'h0;
      case (op)
        4: m_ecap = m_ecap & ~wd;
        5: m_dout = wd;
        6: m_dout = m_dout | wd;
        7: m_dout = m_dout & ~wd;
        8: m_dir  = wd;
        9: m_mask = wd;
        default: ;
      endcase
      m_ecap = m_ecap | ev;
      #1;
      checks++; if (readdata_b !== exp_rd) begin failures++;
        $display("FAIL rand_read it=%0d addr=%0d got=%h exp=%h", it, wa, readdata_b, exp_rd); end
      checks++; if (irq_b !== exp_irq) begin failures++;
        $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq_b, exp_irq); end
      checks++; if (out_port_b !== m_dout) begin failures++;
        $display("FAIL rand_out_port it=%0d got=%h exp=%h", it, out_port_b, m_dout); end
      checks++; if (out_en_b !== m_dir) begin failures++;
        $display("FAIL rand_out_en it=%0d got=%h exp=%h", it, out_en_b, m_dir); end
      cs_b = 1'b0;
      write_n = 1'b1;
      if (it == 150) begin
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_port_b !== RV_B || out_en_b !== DR_B) begin failures++;
          $display("FAIL mid_reset_out got=%h/%h exp=%h/%h", out_port_b, out_en_b, RV_B, DR_B); end
        checks++; if (readdata_b !== 32'h0 || irq_b !== 1'b0) begin failures++;
          $display("FAIL mid_reset_rd_irq got=%h/%b exp=0/0", readdata_b, irq_b); end
        checks++; if (out_port_a !== 8'hA5) begin failures++;
          $display("FAIL mid_reset_a got=%h exp=a5", out_port_a); end
        @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_out_regs();
    test_edge_irq();
    test_level_irq();
    test_random_any();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
